// File: rtl/mask_gen_pkg.sv
// rtl/mask_gen_pkg.sv - shared constants, mode enum and period helper for the mask generator
package mask_gen_pkg;

  localparam int MASK_W = 640;

  typedef enum logic [1:0] {
    MT_SLIDE_R = 2'b00,
    MT_SLIDE_L = 2'b01,
    MT_RANDOM  = 2'b10,
    MT_REPEAT  = 2'b11
  } mask_type_e;

  localparam int          LFSR_W    = 32;
  // Tap mask for x^32+x^22+x^2+x+1 (state bits 31, 21, 1, 0)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0001;

  // Row selector P-1; widths 0 and 9..31 fall back to the full 8-bit period
  function automatic logic [2:0] period_sel(input logic [4:0] pw);
    logic [4:0] pm1;
    pm1 = pw - 5'd1;
    if (pw == 5'd0 || pw > 5'd8) begin
      return 3'd7;
    end
    return pm1[2:0];
  endfunction

endpackage

// File: rtl/mask_generation_vga_lfsr32.sv
// rtl/mask_generation_vga_lfsr32.sv - 32-bit Fibonacci LFSR with data-whitened feedback
module lfsr32
  import mask_gen_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic q
);

  logic [LFSR_W-1:0] state;
  logic              fb;

  assign fb = (^(state & LFSR_TAPS)) ^ din;
  // Output is the bit about to leave the register
  assign q  = state[LFSR_W-1];

  // Shift left, feedback enters at bit 0; reset reloads the seed
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LFSR_SEED;
    end else if (en) begin
      state <= {state[LFSR_W-2:0], fb};
    end
  end

endmodule

// File: rtl/mask_generation_vga.sv
// rtl/mask_generation_vga.sv - 640-pixel VGA mask row generator (slide, random, repeat)
module mask_generation_vga
  import mask_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic [1:0]        mask_type,
  input  logic [4:0]        pattern_w,
  input  logic              pattern,
  input  logic [7:0]        repeatedPattern,
  input  logic              load_pattern,
  output logic [0:MASK_W-1] mg_mask,
  output logic              rp_valid
);

  mask_type_e        mt;
  logic              lfsr_bit;
  logic [2:0]        sel;
  logic [0:MASK_W-1] rows [0:7];
  logic [0:MASK_W-1] rep_row;

  assign mt  = mask_type_e'(mask_type);
  assign sel = period_sel(pattern_w);

  lfsr32 u_lfsr (
    .clk (clk),
    .rst (rst),
    .en  (clk_en && (mt == MT_RANDOM)),
    .din (pattern),
    .q   (lfsr_bit)
  );

  // One fully replicated candidate row per period 1..8; bit P-1 lands on pixel 0
  for (genvar p = 1; p <= 8; p++) begin : g_period
    for (genvar i = 0; i < MASK_W; i++) begin : g_pix
      assign rows[p-1][i] = repeatedPattern[p - 1 - (i % p)];
    end
  end

  // Pick the candidate row matching the effective period
  always_comb begin
    rep_row = rows[sel];
  end

  // Mask row and load-done pulse; nothing moves without clk_en except reset
  always_ff @(posedge clk) begin
    if (rst) begin
      mg_mask  <= '0;
      rp_valid <= 1'b0;
    end else if (clk_en) begin
      rp_valid <= 1'b0;
      case (mt)
        MT_SLIDE_R: mg_mask <= {pattern, mg_mask[0:MASK_W-2]};
        MT_SLIDE_L: mg_mask <= {mg_mask[1:MASK_W-1], pattern};
        MT_RANDOM:  mg_mask <= {lfsr_bit, mg_mask[0:MASK_W-2]};
        MT_REPEAT: begin
          if (load_pattern) begin
            mg_mask  <= rep_row;
            rp_valid <= 1'b1;
          end
        end
        default: mg_mask <= mg_mask;
      endcase
    end
  end

endmodule

// File: tb/tb_mask_generation_vga.sv
// tb/tb_mask_generation_vga.sv - scoreboard bench with random stimulus and directed corner cases
module tb_mask_generation_vga;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clk_en = 1'b0;
  logic [1:0]   mask_type = 2'b00;
  logic [4:0]   pattern_w = 5'd0;
  logic         pattern = 1'b0;
  logic [7:0]   repeated_pattern = 8'h00;
  logic         load_pattern = 1'b0;
  logic [0:639] mg_mask;
  logic         rp_valid;

  typedef struct {
    logic [0:639] mask;
    logic         valid;
  } exp_t;

  exp_t         exp_q[$];
  int           n_cmp = 0;
  int           n_err = 0;

  logic [0:639] m_mask;
  logic         m_valid;
  bit   [31:0]  m_lfsr;

  mask_generation_vga dut (
    .clk             (clk),
    .rst             (rst),
    .clk_en          (clk_en),
    .mask_type       (mask_type),
    .pattern_w       (pattern_w),
    .pattern         (pattern),
    .repeatedPattern (repeated_pattern),
    .load_pattern    (load_pattern),
    .mg_mask         (mg_mask),
    .rp_valid        (rp_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [639:0] act, input logic [639:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference: apply the behavioural rules for one edge, queue the result, then take the edge
  task automatic step(input bit r, input bit en, input int mt, input int pw,
                      input bit pat, input bit [7:0] rp, input bit ld);
    exp_t e;
    int   per;
    bit   ob, fb;
    rst = r; clk_en = en; mask_type = 2'(mt); pattern_w = 5'(pw);
    pattern = pat; repeated_pattern = rp; load_pattern = ld;
    if (r) begin
      m_mask = '0; m_valid = 1'b0; m_lfsr = 32'hACE1_0001;
    end else if (en) begin
      m_valid = 1'b0;
      case (mt)
        0: m_mask = {pat, m_mask[0:638]};
        1: m_mask = {m_mask[1:639], pat};
        2: begin
          ob = m_lfsr[31];
          fb = m_lfsr[31] ^ m_lfsr[21] ^ m_lfsr[1] ^ m_lfsr[0] ^ pat;
          m_lfsr = {m_lfsr[30:0], fb};
          m_mask = {ob, m_mask[0:638]};
        end
        default: if (ld) begin
          per = (pw >= 1 && pw <= 8) ? pw : 8;
          for (int i = 0; i < 640; i++) m_mask[i] = rp[per - 1 - (i % per)];
          m_valid = 1'b1;
        end
      endcase
    end
    e.mask = m_mask; e.valid = m_valid;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare each presented output row against the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("sb_mask", mg_mask, e.mask);
      chk("sb_valid", {639'b0, rp_valid}, {639'b0, e.valid});
    end
  end

  initial begin
    logic [0:639] c;
    logic [0:639] run1;
    logic [0:11]  head;

    // Reset state
    step(1, 0, 0, 0, 0, 8'h00, 0);
    chk("reset_mask", mg_mask, '0);
    chk("reset_valid", {639'b0, rp_valid}, 640'b0);

    // Period 4, 0x0A
    step(0, 1, 3, 4, 0, 8'h0A, 1);
    c = {160{4'hA}};
    chk("p4_mask", mg_mask, c);
    chk("p4_valid", {639'b0, rp_valid}, 640'b1);
    step(0, 1, 3, 4, 0, 8'h0A, 0);
    chk("p4_hold_mask", mg_mask, c);
    chk("p4_hold_valid", {639'b0, rp_valid}, 640'b0);

    // Period 3, 0x06
    step(0, 1, 3, 3, 0, 8'h06, 1);
    head = mg_mask[0:11];
    chk("p3_head", {628'b0, head}, {628'b0, 12'hDB6});
    chk("p3_last", {639'b0, mg_mask[639]}, 640'b1);
    chk("p3_valid", {639'b0, rp_valid}, 640'b1);
    step(0, 1, 3, 3, 0, 8'h06, 0);
    chk("p3_pulse_end", {639'b0, rp_valid}, 640'b0);

    // Out-of-range widths fall back to 8
    c = {80{8'hF0}};
    step(0, 1, 3, 0, 0, 8'hF0, 1);
    chk("pw0_mask", mg_mask, c);
    step(1, 1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 3, 17, 0, 8'hF0, 1);
    chk("pw17_mask", mg_mask, c);

    // Slide right / slide left single pixel
    step(1, 1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 1, 8'h00, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0);
    step(0, 1, 0, 0, 0, 8'h00, 0);
    c = '0; c[2] = 1'b1;
    chk("slide_r", mg_mask, c);
    step(1, 1, 1, 0, 0, 8'h00, 0);
    step(0, 1, 1, 0, 1, 8'h00, 0);
    step(0, 1, 1, 0, 0, 8'h00, 0);
    step(0, 1, 1, 0, 0, 8'h00, 0);
    c = '0; c[637] = 1'b1;
    chk("slide_l", mg_mask, c);

    // Load while disabled is lost; load ignored outside mode 11
    step(1, 1, 3, 4, 0, 8'hFF, 0);
    step(0, 0, 3, 4, 0, 8'hFF, 1);
    chk("noen_mask", mg_mask, '0);
    chk("noen_valid", {639'b0, rp_valid}, 640'b0);
    step(0, 1, 1, 4, 0, 8'hFF, 1);
    chk("ld_mode01_valid", {639'b0, rp_valid}, 640'b0);

    // Reset right after a load
    step(0, 1, 3, 2, 0, 8'h03, 1);
    step(1, 1, 3, 2, 0, 8'h03, 0);
    chk("rst_abort_mask", mg_mask, '0);
    chk("rst_abort_valid", {639'b0, rp_valid}, 640'b0);

    // Held load keeps reloading
    for (int k = 0; k < 3; k++) step(0, 1, 3, 5, 0, 8'(8'h11 + k), 1);
    chk("held_valid", {639'b0, rp_valid}, 640'b1);

    // Random mode reproducible across resets
    step(1, 1, 2, 0, 0, 8'h00, 0);
    for (int k = 0; k < 40; k++) step(0, 1, 2, 0, 0, 8'h00, 0);
    run1 = mg_mask;
    step(1, 1, 2, 0, 0, 8'h00, 0);
    for (int k = 0; k < 40; k++) step(0, 1, 2, 0, 0, 8'h00, 0);
    chk("lfsr_repeat", mg_mask, run1);
    chk("lfsr_nonzero", {639'b0, (mg_mask != '0)}, 640'b1);

    // Randomized traffic against the reference
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 80),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
           1'($urandom), 8'($urandom), 1'($urandom));
    end
    step(0, 0, 0, 0, 0, 8'h00, 0);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    chk("drain", 640'(exp_q.size()), 640'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
